pixel_burst_arbiter: RTL and testbench

Round-robin arbiter that merges up to NUM_SRC pixel AXI-stream sources into the single push port of the shared pixel TX FIFO (data_to_fifo / fifo_push / fifo_full). It grants one source at a time for a bounded burst, prefixes every burst with a header word identifying the source and a per-source sequence number, and back-pressures all sources while the FIFO reports full. It sits between the pixel capture channels and the FIFO feeding the serial TX link.

---
 rtl/pixel_burst_arbiter_pkg.sv | 32 +++
 rtl/pixel_burst_arbiter_rr_pick.sv | 37 +++
 rtl/pixel_burst_arbiter.sv | 139 +++++++++++++
 tb/tb_pixel_burst_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_burst_arbiter_pkg.sv
// Shared definitions for the pixel burst arbiter: header word layout,
// FSM state encoding and the header-building helper.
package pixel_burst_arbiter_pkg;

   localparam logic [7:0] HDR_MAGIC     = 8'hA5;
   localparam int         HDR_WIDTH     = 48;
   localparam int         HDR_MAGIC_LSB = 40;
   localparam int         HDR_MAGIC_W   = 8;
   localparam int         HDR_SRC_LSB   = 36;
   localparam int         HDR_SRC_W     = 4;
   localparam int         HDR_SEQ_LSB   = 20;
   localparam int         HDR_SEQ_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2
   } arb_state_t;

   // Header: magic in the top byte, source id, per-source sequence number,
   // low 20 bits left zero for future use by the link layer.
   function automatic logic [HDR_WIDTH-1:0] make_header(input logic [HDR_SRC_W-1:0] src,
                                                        input logic [HDR_SEQ_W-1:0] seq);
      logic [HDR_WIDTH-1:0] h;
      h = '0;
      h[HDR_MAGIC_LSB +: HDR_MAGIC_W] = HDR_MAGIC;
      h[HDR_SRC_LSB   +: HDR_SRC_W]   = src;
      h[HDR_SEQ_LSB   +: HDR_SEQ_W]   = seq;
      return h;
   endfunction

endpackage

// File: rtl/pixel_burst_arbiter_rr_pick.sv
// Combinational round-robin search: starting just after last_grant and
// wrapping, return the first source whose valid bit is set.
module rr_pick
   import pixel_burst_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0] valid,
   input  logic [3:0]         last_grant,
   output logic [3:0]         next_idx,
   output logic               any_valid
);

   logic [15:0] valid_ext;
   logic [4:0]  cand;

   assign valid_ext = 16'(valid);

   // Walk candidates from farthest to nearest so the nearest valid source
   // after last_grant is the one that sticks.
   always_comb begin
      next_idx  = '0;
      any_valid = 1'b0;
      cand      = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         cand = {1'b0, last_grant} + 5'(k);
         if (cand >= 5'(NUM_SRC)) begin
            cand = cand - 5'(NUM_SRC);
         end
         if (valid_ext[cand[3:0]]) begin
            next_idx  = cand[3:0];
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_burst_arbiter.sv
// Round-robin merge of several pixel AXI-stream sources into the single push
// port of the shared TX FIFO. Each grant emits a header word followed by up
// to BURST_LEN data beats; a full FIFO stalls everything.
module pixel_burst_arbiter
   import pixel_burst_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 48,
   parameter int NUM_SRC    = 4,
   parameter int BURST_LEN  = 64
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          enable,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_SRC-1:0]            s_tvalid,
   input  logic [NUM_SRC-1:0]            s_tlast,
   output logic [NUM_SRC-1:0]            s_tready,
   output logic [DATA_WIDTH-1:0]         data_to_fifo,
   output logic                          fifo_push,
   input  logic                          fifo_full,
   output logic [3:0]                    grant_id,
   output logic                          busy,
   output logic                          burst_done,
   output logic [31:0]                   burst_count
);

   localparam int CNT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

   arb_state_t            state;
   logic [3:0]            last_grant;
   logic [15:0]           seq [NUM_SRC];
   logic [CNT_W-1:0]      beat_cnt;
   logic [3:0]            next_idx;
   logic                  any_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_last;
   logic [15:0]           sel_seq;
   logic [DATA_WIDTH-1:0] hdr_word;
   logic                  accept;
   logic                  last_beat;

   rr_pick #(
      .NUM_SRC(NUM_SRC)
   ) u_rr_pick (
      .valid     (s_tvalid),
      .last_grant(last_grant),
      .next_idx  (next_idx),
      .any_valid (any_valid)
   );

   // Route the granted source's stream signals and sequence number.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_seq   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_id == 4'(i)) begin
            sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_valid = s_tvalid[i];
            sel_last  = s_tlast[i];
            sel_seq   = seq[i];
         end
      end
   end

   // Only the granted source sees ready, and only while the FIFO has room.
   always_comb begin
      s_tready = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         s_tready[i] = (state == ST_DATA) && (grant_id == 4'(i)) && !fifo_full;
      end
   end

   assign accept    = (state == ST_DATA) && sel_valid && !fifo_full;
   assign last_beat = sel_last || (beat_cnt == CNT_W'(BURST_LEN - 1));
   assign hdr_word  = DATA_WIDTH'(make_header(grant_id, sel_seq));
   assign busy      = (state != ST_IDLE);

   // Burst FSM with registered FIFO push, sequence and burst bookkeeping.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state        <= ST_IDLE;
         grant_id     <= '0;
         last_grant   <= 4'(NUM_SRC - 1);
         beat_cnt     <= '0;
         data_to_fifo <= '0;
         fifo_push    <= 1'b0;
         burst_done   <= 1'b0;
         burst_count  <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            seq[i] <= '0;
         end
      end else begin
         fifo_push  <= 1'b0;
         burst_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable && any_valid) begin
                  grant_id <= next_idx;
                  state    <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (!fifo_full) begin
                  data_to_fifo <= hdr_word;
                  fifo_push    <= 1'b1;
                  beat_cnt     <= '0;
                  state        <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (accept) begin
                  data_to_fifo <= sel_data;
                  fifo_push    <= 1'b1;
                  if (last_beat) begin
                     for (int i = 0; i < NUM_SRC; i++) begin
                        if (grant_id == 4'(i)) begin
                           seq[i] <= seq[i] + 16'd1;
                        end
                     end
                     burst_count <= burst_count + 32'd1;
                     burst_done  <= 1'b1;
                     last_grant  <= grant_id;
                     state       <= ST_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_burst_arbiter.sv
// Scoreboard bench for pixel_burst_arbiter: per-source beat queues drive the
// streams, a burst-level reference model predicts the FIFO word sequence.
module tb_pixel_burst_arbiter;

   localparam int DW = 48;
   localparam int NS = 4;
   localparam int BL = 4;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic             enable = 1'b0;
   logic [NS*DW-1:0] s_tdata = '0;
   logic [NS-1:0]    s_tvalid = '0;
   logic [NS-1:0]    s_tlast = '0;
   logic [NS-1:0]    s_tready;
   logic [DW-1:0]    data_to_fifo;
   logic             fifo_push;
   logic             fifo_full = 1'b0;
   logic [3:0]       grant_id;
   logic             busy;
   logic             burst_done;
   logic [31:0]      burst_count;

   int errors = 0;
   int checks = 0;

   logic [DW:0]   drv_q [NS][$];
   logic [DW:0]   mod_q [NS][$];
   logic [DW-1:0] exp_q [$];
   logic [15:0]   m_seq [NS];
   int            m_last;
   int            m_bursts;
   int            bd_count;
   int            rx_count = 0;
   int            full_mode = 0;

   pixel_burst_arbiter #(
      .DATA_WIDTH(DW),
      .NUM_SRC   (NS),
      .BURST_LEN (BL)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .enable      (enable),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tlast     (s_tlast),
      .s_tready    (s_tready),
      .data_to_fifo(data_to_fifo),
      .fifo_push   (fifo_push),
      .fifo_full   (fifo_full),
      .grant_id    (grant_id),
      .busy        (busy),
      .burst_done  (burst_done),
      .burst_count (burst_count)
   );

   // Free-running clock.
   always #5 aclk = ~aclk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name, input int actual, input int required);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, required);
   endtask

   // Queue one beat for a source, both for the driver and the model.
   task automatic applyStimulus(input int src, input logic [DW-1:0] data, input logic last);
      drv_q[src].push_back({last, data});
      mod_q[src].push_back({last, data});
   endtask

   task automatic modelReset();
      for (int i = 0; i < NS; i++) begin
         drv_q[i].delete();
         mod_q[i].delete();
         m_seq[i] = '0;
      end
      exp_q.delete();
      m_last   = NS - 1;
      m_bursts = 0;
      bd_count = 0;
   endtask

   // Burst-level model: repeatedly grant the next non-empty source after the
   // previous one, emit its header, then beats until tlast or BL beats.
   task automatic modelDrain();
      int src;
      int cand;
      int n;
      bit found;
      logic [DW:0]   b;
      logic [DW-1:0] hdr;
      forever begin
         found = 1'b0;
         src   = 0;
         for (int k = 1; k <= NS; k++) begin
            cand = (m_last + k) % NS;
            if (!found && mod_q[cand].size() > 0) begin
               found = 1'b1;
               src   = cand;
            end
         end
         if (!found) break;
         hdr = '0;
         hdr[47:40] = 8'hA5;
         hdr[39:36] = 4'(src);
         hdr[35:20] = m_seq[src];
         exp_q.push_back(hdr);
         n = 0;
         do begin
            b = mod_q[src].pop_front();
            exp_q.push_back(b[DW-1:0]);
            n++;
         end while (!b[DW] && n < BL && mod_q[src].size() > 0);
         m_seq[src] = m_seq[src] + 16'd1;
         m_bursts++;
         m_last = src;
      end
   endtask

   task automatic waitRx(input int target, input int budget);
      int cyc;
      cyc = 0;
      while (rx_count < target) begin
         @(negedge aclk);
         #1;
         cyc++;
         if (cyc >= budget) begin
            failNow("rx wait timeout", rx_count, target);
            break;
         end
      end
   endtask

   task automatic waitDrained(input int budget);
      int cyc;
      bit empty;
      cyc = 0;
      forever begin
         @(negedge aclk);
         #1;
         empty = (exp_q.size() == 0);
         for (int i = 0; i < NS; i++) begin
            if (drv_q[i].size() != 0) empty = 1'b0;
         end
         if (empty) break;
         cyc++;
         if (cyc >= budget) begin
            failNow("drain timeout pending words", exp_q.size(), 0);
            break;
         end
      end
      repeat (3) @(negedge aclk);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " data_to_fifo"}, 64'(data_to_fifo), 64'h0);
      checkOutput({tag, " fifo_push"}, 64'(fifo_push), 64'h0);
      checkOutput({tag, " grant_id"}, 64'(grant_id), 64'h0);
      checkOutput({tag, " busy"}, 64'(busy), 64'h0);
      checkOutput({tag, " burst_done"}, 64'(burst_done), 64'h0);
      checkOutput({tag, " burst_count"}, 64'(burst_count), 64'h0);
      checkOutput({tag, " s_tready"}, 64'(s_tready), 64'h0);
   endtask

   function automatic logic [DW-1:0] rndWord();
      logic [63:0] w;
      w = {$urandom(), $urandom()};
      return w[DW-1:0];
   endfunction

   // Source driver: present queue heads, randomise FIFO fullness, then pop
   // every beat that will be accepted at the coming rising edge.
   always @(negedge aclk) begin
      logic [DW:0] h;
      case (full_mode)
         0:       fifo_full = 1'b0;
         1:       fifo_full = ($urandom_range(0, 3) == 0);
         default: fifo_full = 1'b1;
      endcase
      for (int i = 0; i < NS; i++) begin
         if (drv_q[i].size() > 0) begin
            h = drv_q[i][0];
            s_tvalid[i] = 1'b1;
            s_tlast[i]  = h[DW];
            s_tdata[i*DW +: DW] = h[DW-1:0];
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            s_tdata[i*DW +: DW] = '0;
         end
      end
      #1;
      for (int j = 0; j < NS; j++) begin
         if (s_tvalid[j] && s_tready[j] && drv_q[j].size() > 0) begin
            void'(drv_q[j].pop_front());
         end
      end
   end

   // Monitor: every FIFO push is compared against the predicted word stream.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (burst_done) bd_count++;
         if (fifo_push) begin
            rx_count++;
            if (exp_q.size() == 0) begin
               failNow("unexpected push count", rx_count, rx_count - 1);
            end else begin
               checkOutput("fifo word", 64'(data_to_fifo), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   // Runaway guard.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int rx_base;
      int pushes;
      int n;

      modelReset();
      aresetn = 1'b0;
      enable  = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      checkResetOutputs("reset");

      @(negedge aclk);
      aresetn = 1'b1;
      enable  = 1'b1;

      // All sources valid, no tlast: grant order 0,1,2,3,0.
      @(posedge aclk);
      #2;
      for (int b = 0; b < 2 * BL; b++) applyStimulus(0, rndWord(), 1'b0);
      for (int s = 1; s < NS; s++) begin
         for (int b = 0; b < BL; b++) applyStimulus(s, rndWord(), 1'b0);
      end
      modelDrain();
      waitDrained(400);
      checkOutput("all4 burst_count", 64'(burst_count), 64'd5);
      checkOutput("all4 burst_done pulses", 64'(bd_count), 64'd5);
      checkOutput("all4 last grant", 64'(grant_id), 64'd0);

      // Single source 2, 10 beats with tlast on the 10th.
      @(posedge aclk);
      #2;
      for (int b = 1; b <= 10; b++) applyStimulus(2, 48'h0000_0200_0000 + 48'(b), b == 10);
      modelDrain();
      waitDrained(400);
      checkOutput("single burst_count", 64'(burst_count), 64'(m_bursts));
      checkOutput("single grant_id", 64'(grant_id), 64'd2);
      checkOutput("single busy idle", 64'(busy), 64'd0);

      // FIFO full for 20 cycles in the middle of a burst.
      @(posedge aclk);
      #2;
      for (int b = 0; b < 12; b++) applyStimulus(0, rndWord(), b == 11);
      modelDrain();
      rx_base = rx_count;
      waitRx(rx_base + 3, 100);
      @(posedge aclk);
      #2;
      full_mode = 2;
      for (int c = 0; c < 20; c++) begin
         @(negedge aclk);
         #2;
         checkOutput("full s_tready", 64'(s_tready), 64'h0);
         if (c >= 1) checkOutput("full no push", 64'(fifo_push), 64'h0);
      end
      @(posedge aclk);
      #2;
      full_mode = 0;
      waitDrained(400);
      checkOutput("full burst_count", 64'(burst_count), 64'(m_bursts));

      // Randomised traffic with random tlast and random FIFO fullness.
      for (int r = 0; r < 6; r++) begin
         @(posedge aclk);
         #2;
         for (int s = 0; s < NS; s++) begin
            n = $urandom_range(0, 10);
            for (int b = 0; b < n; b++) begin
               applyStimulus(s, rndWord(), (b == n - 1) || ($urandom_range(0, 3) == 0));
            end
         end
         modelDrain();
         full_mode = 1;
         waitDrained(2000);
         full_mode = 0;
      end
      checkOutput("random burst_count", 64'(burst_count), 64'(m_bursts));
      checkOutput("random burst_done pulses", 64'(bd_count), 64'(m_bursts));

      // enable dropped mid-burst from source 1: burst finishes, then nothing.
      @(posedge aclk);
      #2;
      for (int b = 0; b < 2 * BL; b++) applyStimulus(1, rndWord(), 1'b0);
      modelDrain();
      rx_base = rx_count;
      waitRx(rx_base + 3, 100);
      @(posedge aclk);
      #2;
      enable = 1'b0;
      repeat (6) @(negedge aclk);
      pushes = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge aclk);
         #1;
         if (fifo_push) pushes++;
      end
      checkOutput("pause pushes", 64'(pushes), 64'd0);
      checkOutput("pause words", 64'(rx_count - rx_base), 64'(BL + 1));
      checkOutput("pause busy", 64'(busy), 64'd0);
      @(posedge aclk);
      #2;
      enable = 1'b1;
      waitDrained(400);
      checkOutput("enable burst_count", 64'(burst_count), 64'(m_bursts));

      // Reset while in DATA with the FIFO full.
      @(posedge aclk);
      #2;
      for (int b = 0; b < 2 * BL; b++) applyStimulus(2, rndWord(), 1'b0);
      modelDrain();
      rx_base = rx_count;
      waitRx(rx_base + 2, 100);
      @(posedge aclk);
      #2;
      full_mode = 2;
      repeat (2) @(negedge aclk);
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      checkResetOutputs("midreset");
      modelReset();
      full_mode = 0;
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #2;
      for (int b = 0; b < 3; b++) applyStimulus(3, rndWord(), b == 2);
      for (int b = 0; b < 3; b++) applyStimulus(1, rndWord(), b == 2);
      modelDrain();
      waitDrained(400);
      checkOutput("post-reset burst_count", 64'(burst_count), 64'd2);
      checkOutput("post-reset last grant", 64'(grant_id), 64'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
